// File: rtl/aes_round_ctrl.sv
// Round-sequencing controller for the AES core: drives the external round counter and turns its
// count into per-round datapath enables, the round index and the final-round flag.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  input  logic [3:0] count,
  output logic       cnt_rst_n,
  output logic       cnt_start,
  output logic       cnt_stop,
  output logic       ld_state,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic       final_round,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] NR4  = 4'(NR);
  localparam logic [3:0] LAST = 4'(NR - 1);

  state_t state, state_nxt;
  logic   desync;

  // the counter must never reach NR while rounds are still being issued
  assign desync = (state == RUN) && (count >= NR4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  err <= 1'b0;
    else if (desync && !flush) err <= 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = RUN;
        RUN:     if (desync) state_nxt = IDLE;
                 else if (count == LAST) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready    = 1'b0;
    cnt_rst_n   = 1'b1;
    cnt_start   = 1'b0;
    cnt_stop    = 1'b0;
    ld_state    = 1'b0;
    round_en    = 1'b0;
    round_idx   = 4'd0;
    final_round = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    if (rst) begin
      cnt_rst_n = 1'b0;
      cnt_stop  = 1'b1;
    end else if (flush) begin
      cnt_rst_n = 1'b0;
      cnt_stop  = 1'b1;
      busy      = (state != IDLE);
    end else begin
      case (state)
        IDLE: begin
          in_ready  = 1'b1;
          cnt_rst_n = in_valid;
          ld_state  = in_valid;
          cnt_start = in_valid;
        end
        RUN: begin
          busy      = 1'b1;
          round_idx = count + 4'd1;
          if (desync) cnt_stop = 1'b1;
          else begin
            round_en = 1'b1;
            if (count == LAST) begin
              final_round = 1'b1;
              cnt_stop    = 1'b1;
            end
          end
        end
        DONE: begin
          busy      = 1'b1;
          out_valid = 1'b1;
          // clear on the way out so a back-to-back accept starts from round 1
          cnt_rst_n = ~out_ready;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: NR=10 and NR=14 instances with a behavioural round counter,
// per-round/per-block expectations queued at stimulus time and checked by a negedge monitor.
module tb_aes_round_ctrl;
  localparam int NR0 = 10, NR1 = 14;
  localparam int S_IN_READY = 0, S_BUSY = 1, S_ERR = 2, S_COUNT = 3, S_OUT_VALID = 4,
                 S_ROUND_EN = 5, S_LD = 6, S_CNT_START = 7, S_CNT_RST_N = 8, S_CNT_STOP = 9,
                 S_ROUND_IDX = 10;

  typedef struct { int cyc; bit is_done; int idx; bit fin; } ev_t;
  typedef struct { int cyc; int d; int sig; int val; } probe_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid [2], flush [2], out_ready [2], force_en [2];
  logic in_ready [2], cnt_rst_n [2], cnt_start [2], cnt_stop [2], ld_state [2];
  logic round_en [2], final_round [2], out_valid [2], busy [2], err [2];
  logic [3:0] round_idx [2];
  logic [3:0] count [2] = '{4'd0, 4'd0};
  logic armed [2] = '{1'b0, 1'b0};
  logic [3:0] force_val;

  int cyc = 0;
  bit done = 1'b0;
  int n_chk = 0, n_fail = 0;
  ev_t sbq [2][$];
  probe_t probe_q [$];
  string sname [11] = '{"in_ready", "busy", "err", "count", "out_valid", "round_en",
                        "ld_state", "cnt_start", "cnt_rst_n", "cnt_stop", "round_idx"};

  aes_round_ctrl #(.NR(NR0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .flush(flush[0]),
    .count(count[0]), .cnt_rst_n(cnt_rst_n[0]), .cnt_start(cnt_start[0]), .cnt_stop(cnt_stop[0]),
    .ld_state(ld_state[0]), .round_en(round_en[0]), .round_idx(round_idx[0]),
    .final_round(final_round[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .err(err[0]));

  aes_round_ctrl #(.NR(NR1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .flush(flush[1]),
    .count(count[1]), .cnt_rst_n(cnt_rst_n[1]), .cnt_start(cnt_start[1]), .cnt_stop(cnt_stop[1]),
    .ld_state(ld_state[1]), .round_en(round_en[1]), .round_idx(round_idx[1]),
    .final_round(final_round[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .err(err[1]));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural round counter; force_en overrides it to provoke a desync
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (force_en[d])        count[d] <= force_val;
      else if (!cnt_rst_n[d]) count[d] <= 4'd0;
      else if (armed[d])      count[d] <= count[d] + 4'd1;
      if (!cnt_rst_n[d] || cnt_stop[d]) armed[d] <= 1'b0;
      else if (cnt_start[d])            armed[d] <= 1'b1;
    end
  end

  function automatic int sigval(int d, int s);
    case (s)
      S_IN_READY:  return int'(in_ready[d]);
      S_BUSY:      return int'(busy[d]);
      S_ERR:       return int'(err[d]);
      S_COUNT:     return int'(count[d]);
      S_OUT_VALID: return int'(out_valid[d]);
      S_ROUND_EN:  return int'(round_en[d]);
      S_LD:        return int'(ld_state[d]);
      S_CNT_START: return int'(cnt_start[d]);
      S_CNT_RST_N: return int'(cnt_rst_n[d]);
      S_CNT_STOP:  return int'(cnt_stop[d]);
      S_ROUND_IDX: return int'(round_idx[d]);
      default:     return -1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic probe(input int c, input int d, input int s, input int v);
    probe_t p;
    p.cyc = c; p.d = d; p.sig = s; p.val = v;
    probe_q.push_back(p);
  endtask

  task automatic push_rounds(input int d, input int t0, input int first, input int last, input int nr);
    ev_t e;
    for (int k = first; k <= last; k++) begin
      e.cyc = t0 + k; e.is_done = 1'b0; e.idx = k; e.fin = (k == nr);
      sbq[d].push_back(e);
    end
  endtask

  task automatic push_done(input int d, input int c);
    ev_t e;
    e.cyc = c; e.is_done = 1'b1; e.idx = 0; e.fin = 1'b0;
    sbq[d].push_back(e);
  endtask

  // full block with out_ready=1: accept now, rounds at +1..+nr, result at +nr+1
  task automatic run_block(input int d, input int nr);
    int t0;
    t0 = cyc;
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b1;
    probe(t0, d, S_LD, 1);
    probe(t0, d, S_CNT_START, 1);
    push_rounds(d, t0, 1, nr, nr);
    push_done(d, t0 + nr + 1);
    probe(t0 + nr + 1, d, S_OUT_VALID, 1);
    probe(t0 + nr + 1, d, S_IN_READY, 0);
    tick();
    in_valid[d] = 1'b0;
    goto(t0 + nr + 3);
  endtask

  // stimulus
  initial begin
    int t0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; flush[d] = 1'b0; out_ready[d] = 1'b0; force_en[d] = 1'b0;
    end
    force_val = 4'd12;
    tick(); tick();
    probe(cyc, 0, S_IN_READY, 0);  probe(cyc, 0, S_BUSY, 0);      probe(cyc, 0, S_CNT_RST_N, 0);
    probe(cyc, 0, S_CNT_STOP, 1);  probe(cyc, 0, S_OUT_VALID, 0); probe(cyc, 0, S_ERR, 0);
    probe(cyc, 0, S_ROUND_IDX, 0);
    tick();
    rst = 1'b0;
    probe(cyc, 0, S_IN_READY, 1);  probe(cyc, 0, S_CNT_RST_N, 0); probe(cyc, 0, S_CNT_STOP, 0);
    probe(cyc, 0, S_COUNT, 0);     probe(cyc, 0, S_BUSY, 0);
    tick();

    // single NR=10 block
    t0 = cyc;
    probe(t0 + 1, 0, S_COUNT, 0);  probe(t0 + 11, 0, S_COUNT, 10); probe(t0 + 11, 0, S_BUSY, 1);
    probe(t0 + 12, 0, S_BUSY, 0);  probe(t0 + 12, 0, S_IN_READY, 1);
    run_block(0, NR0);

    // result held 5 cycles by out_ready=0
    t0 = cyc;
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    push_rounds(0, t0, 1, NR0, NR0);
    push_done(0, t0 + 16);
    for (int k = 11; k <= 15; k++) begin
      probe(t0 + k, 0, S_OUT_VALID, 1); probe(t0 + k, 0, S_COUNT, 10); probe(t0 + k, 0, S_IN_READY, 0);
    end
    probe(t0 + 17, 0, S_BUSY, 0);
    probe(t0 + 18, 0, S_COUNT, 0);
    tick();
    in_valid[0] = 1'b0;
    goto(t0 + 16);
    out_ready[0] = 1'b1;
    goto(t0 + 19);

    // async reset during round 4
    t0 = cyc;
    in_valid[0] = 1'b1;
    push_rounds(0, t0, 1, 3, NR0);
    tick();
    in_valid[0] = 1'b0;
    goto(t0 + 4);
    rst = 1'b1;
    probe(t0 + 4, 0, S_BUSY, 0);      probe(t0 + 4, 0, S_IN_READY, 0);  probe(t0 + 4, 0, S_ROUND_EN, 0);
    probe(t0 + 4, 0, S_OUT_VALID, 0); probe(t0 + 4, 0, S_ERR, 0);       probe(t0 + 4, 0, S_CNT_STOP, 1);
    probe(t0 + 4, 0, S_CNT_RST_N, 0); probe(t0 + 4, 0, S_ROUND_IDX, 0);
    tick();
    rst = 1'b0;
    probe(cyc, 0, S_COUNT, 0); probe(cyc, 0, S_IN_READY, 1); probe(cyc, 0, S_BUSY, 0);
    tick();
    run_block(0, NR0);
    probe(cyc, 0, S_ERR, 0);
    tick();

    // flush during round 6
    t0 = cyc;
    in_valid[0] = 1'b1;
    push_rounds(0, t0, 1, 5, NR0);
    probe(t0 + 6, 0, S_ROUND_EN, 0);  probe(t0 + 6, 0, S_IN_READY, 0); probe(t0 + 6, 0, S_CNT_STOP, 1);
    probe(t0 + 6, 0, S_CNT_RST_N, 0); probe(t0 + 6, 0, S_BUSY, 1);
    probe(t0 + 7, 0, S_BUSY, 0);      probe(t0 + 7, 0, S_COUNT, 0);    probe(t0 + 11, 0, S_OUT_VALID, 0);
    tick();
    in_valid[0] = 1'b0;
    goto(t0 + 6);
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    goto(t0 + 14);
    run_block(0, NR0);

    // counter desync: count forced to 12 during round 4
    t0 = cyc;
    in_valid[0] = 1'b1;
    push_rounds(0, t0, 1, 3, NR0);
    probe(t0 + 4, 0, S_ROUND_EN, 0); probe(t0 + 4, 0, S_CNT_STOP, 1); probe(t0 + 4, 0, S_ERR, 0);
    probe(t0 + 4, 0, S_BUSY, 1);     probe(t0 + 5, 0, S_ERR, 1);      probe(t0 + 5, 0, S_BUSY, 0);
    probe(t0 + 5, 0, S_IN_READY, 1);
    tick();
    in_valid[0] = 1'b0;
    goto(t0 + 3);
    force_en[0] = 1'b1;
    tick();
    force_en[0] = 1'b0;
    goto(t0 + 7);
    run_block(0, NR0);
    probe(cyc, 0, S_ERR, 1);
    tick();

    // NR=14 back-to-back, one block every 16 cycles
    t0 = cyc;
    in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      push_rounds(1, t0 + 16 * b, 1, NR1, NR1);
      push_done(1, t0 + 16 * b + 15);
      probe(t0 + 16 * b, 1, S_LD, 1);
      probe(t0 + 16 * b + 15, 1, S_IN_READY, 0);
      probe(t0 + 16 * b + 15, 1, S_LD, 0);
    end
    goto(t0 + 33);
    in_valid[1] = 1'b0;
    goto(t0 + 50);
    probe(cyc, 1, S_ERR, 0); probe(cyc, 1, S_BUSY, 0);
    tick(); tick();
    done = 1'b1;
  end

  // monitor
  initial begin
    ev_t m_ev;
    int m_i, m_v;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (final_round[d] && !round_en[d]) begin
          n_fail++;
          $display("FAIL final_round dut%0d cyc %0d: final_round=1 with round_en=0, required round_en=1", d, cyc);
        end
        if (round_en[d]) begin
          n_chk++;
          if (sbq[d].size() == 0) begin
            n_fail++;
            $display("FAIL round dut%0d cyc %0d: unexpected round idx %0d, required no round", d, cyc, round_idx[d]);
          end else begin
            m_ev = sbq[d].pop_front();
            if (m_ev.is_done || m_ev.cyc != cyc || m_ev.idx != int'(round_idx[d]) || m_ev.fin != final_round[d]) begin
              n_fail++;
              $display("FAIL round dut%0d: got cyc %0d idx %0d fin %0d, required cyc %0d idx %0d fin %0d done %0d",
                       d, cyc, round_idx[d], final_round[d], m_ev.cyc, m_ev.idx, m_ev.fin, m_ev.is_done);
            end
          end
        end
        if (out_valid[d] && out_ready[d]) begin
          n_chk++;
          if (sbq[d].size() == 0) begin
            n_fail++;
            $display("FAIL result dut%0d cyc %0d: unexpected out_valid handshake, required none", d, cyc);
          end else begin
            m_ev = sbq[d].pop_front();
            if (!m_ev.is_done || m_ev.cyc != cyc) begin
              n_fail++;
              $display("FAIL result dut%0d: got handshake at cyc %0d, required cyc %0d (result expected %0d)",
                       d, cyc, m_ev.cyc, m_ev.is_done);
            end
          end
        end
      end
      m_i = 0;
      while (m_i < probe_q.size()) begin
        if (probe_q[m_i].cyc <= cyc) begin
          n_chk++;
          m_v = sigval(probe_q[m_i].d, probe_q[m_i].sig);
          if (probe_q[m_i].cyc != cyc || m_v != probe_q[m_i].val) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %0d, required %0d (due cyc %0d)", sname[probe_q[m_i].sig],
                     probe_q[m_i].d, cyc, m_v, probe_q[m_i].val, probe_q[m_i].cyc);
          end
          probe_q.delete(m_i);
        end else m_i++;
      end
      if (cyc > 3000) begin
        $display("FAIL watchdog cyc %0d: bench did not finish, required end before 3000", cyc);
        $fatal(1, "watchdog expired");
      end
      if (done) begin
        for (int d = 0; d < 2; d++) begin
          n_chk++;
          if (sbq[d].size() != 0) begin
            n_fail++;
            $display("FAIL drain dut%0d: %0d expected events outstanding, required 0", d, sbq[d].size());
          end
        end
        n_chk++;
        if (probe_q.size() != 0) begin
          n_fail++;
          $display("FAIL probes: %0d unchecked, required 0", probe_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

endmodule
